// File: rtl/draw_sequencer_pkg.sv
// Shared definitions for the region raster sequencer and its counters.
package draw_sequencer_pkg;

  localparam int unsigned FS_W = 160;
  localparam int unsigned FS_H = 120;
  localparam int unsigned CV_W = 115;
  localparam int unsigned CV_H = 70;
  localparam int unsigned AN_W = 21;
  localparam int unsigned AN_H = 17;

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned PW = 15;

  // Region codes must match the address ALU opcode encoding.
  typedef enum logic [1:0] {
    REGION_FULLSCREEN = 2'b00,
    REGION_CANVAS     = 2'b01,
    REGION_ANSWER     = 2'b10,
    REGION_ILLEGAL    = 2'b11
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DRAW = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Scan limits for one region: first/last x offset and last row.
  typedef struct packed {
    logic [XW-1:0] first_x;
    logic [XW-1:0] last_x;
    logic [YW-1:0] last_y;
  } scan_cfg_t;

  // Fullscreen x runs 1..W because the ALU subtracts one in that mode.
  function automatic scan_cfg_t region_cfg(input region_e r);
    scan_cfg_t c;
    c = '0;
    case (r)
      REGION_FULLSCREEN: begin
        c.first_x = XW'(1);
        c.last_x  = XW'(FS_W);
        c.last_y  = YW'(FS_H - 1);
      end
      REGION_CANVAS: begin
        c.first_x = XW'(0);
        c.last_x  = XW'(CV_W - 1);
        c.last_y  = YW'(CV_H - 1);
      end
      default: begin
        c.first_x = XW'(0);
        c.last_x  = XW'(AN_W - 1);
        c.last_y  = YW'(AN_H - 1);
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/draw_sequencer_counter.sv
// Row-major x/y scan counters plus a linear pixel index (incrementer only).
module draw_sequencer_counter
  import draw_sequencer_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [XW-1:0] i_first_x,
  input  logic [XW-1:0] i_last_x,
  input  logic [YW-1:0] i_last_y,
  output logic [XW-1:0] o_xpos,
  output logic [YW-1:0] o_ypos,
  output logic [PW-1:0] o_pix_index,
  output logic          o_last_c
);

  logic w_last_x;

  assign w_last_x = (o_xpos == i_last_x);
  assign o_last_c = w_last_x && (o_ypos == i_last_y);

  // Clear wins over load, load over advance; x wraps to its first value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      o_xpos      <= '0;
      o_ypos      <= '0;
      o_pix_index <= '0;
    end else if (i_clr) begin
      o_xpos      <= '0;
      o_ypos      <= '0;
      o_pix_index <= '0;
    end else if (i_load) begin
      o_xpos      <= i_first_x;
      o_ypos      <= '0;
      o_pix_index <= '0;
    end else if (i_en) begin
      o_pix_index <= o_pix_index + PW'(1);
      if (w_last_x) begin
        o_xpos <= i_first_x;
        o_ypos <= o_ypos + YW'(1);
      end else begin
        o_xpos <= o_xpos + XW'(1);
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Rasters one rectangular region per request, one plot per cycle, then pulses done.
module draw_sequencer
  import draw_sequencer_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic          go,
  input  logic [1:0]    region,
  input  logic [XW-1:0] start_x_in,
  input  logic [YW-1:0] start_y_in,
  input  logic          abort,
  output logic          busy,
  output logic          plot,
  output logic [XW-1:0] Xpos,
  output logic [YW-1:0] Ypos,
  output logic [XW-1:0] startX,
  output logic [YW-1:0] startY,
  output logic [1:0]    aluOp,
  output logic [PW-1:0] pix_index,
  output logic          done,
  output logic          err
);

  state_e        r_state;
  scan_cfg_t     r_cfg;
  scan_cfg_t     w_new_cfg;
  logic          w_idle;
  logic          w_drawing;
  logic          w_accept;
  logic          w_reject;
  logic          w_last;
  logic          w_step;
  logic          w_clr;
  logic [XW-1:0] w_first_x;

  assign w_new_cfg = region_cfg(region_e'(region));
  assign w_idle    = (r_state == ST_IDLE);
  assign w_drawing = (r_state == ST_DRAW);
  assign w_accept  = w_idle && go && (region != REGION_ILLEGAL);
  assign w_reject  = w_idle && go && (region == REGION_ILLEGAL);
  assign w_step    = w_drawing && !abort && !w_last;
  assign w_clr     = w_drawing && (abort || w_last);
  // On accept the counters need the new region's first x before it is latched.
  assign w_first_x = w_accept ? w_new_cfg.first_x : r_cfg.first_x;

  draw_sequencer_counter u_counter (
    .clock      (clock),
    .resetn     (resetn),
    .i_clr      (w_clr),
    .i_load     (w_accept),
    .i_en       (w_step),
    .i_first_x  (w_first_x),
    .i_last_x   (r_cfg.last_x),
    .i_last_y   (r_cfg.last_y),
    .o_xpos     (Xpos),
    .o_ypos     (Ypos),
    .o_pix_index(pix_index),
    .o_last_c   (w_last)
  );

  // Sequencer FSM with registered status/ALU-setup outputs; abort beats last pixel.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cfg   <= '0;
      busy    <= 1'b0;
      plot    <= 1'b0;
      startX  <= '0;
      startY  <= '0;
      aluOp   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_DRAW;
            r_cfg   <= w_new_cfg;
            busy    <= 1'b1;
            plot    <= 1'b1;
            aluOp   <= region;
            if (region == REGION_FULLSCREEN) begin
              startX <= '0;
              startY <= '0;
            end else begin
              startX <= start_x_in;
              startY <= start_y_in;
            end
          end else if (w_reject) begin
            err <= 1'b1;
          end
        end
        ST_DRAW: begin
          if (abort) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            plot    <= 1'b0;
          end else if (w_last) begin
            r_state <= ST_DONE;
            plot    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          plot    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench: table of draws, corner sequences, then randomized draws.
module tb_draw_sequencer;

  logic       clock;
  logic       resetn;
  logic       go;
  logic [1:0] region;
  logic [7:0] start_x_in;
  logic [6:0] start_y_in;
  logic       abort;
  logic       busy;
  logic       plot;
  logic [7:0] Xpos;
  logic [6:0] Ypos;
  logic [7:0] startX;
  logic [6:0] startY;
  logic [1:0] aluOp;
  logic [14:0] pix_index;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  draw_sequencer dut (
    .clock     (clock),
    .resetn    (resetn),
    .go        (go),
    .region    (region),
    .start_x_in(start_x_in),
    .start_y_in(start_y_in),
    .abort     (abort),
    .busy      (busy),
    .plot      (plot),
    .Xpos      (Xpos),
    .Ypos      (Ypos),
    .startX    (startX),
    .startY    (startY),
    .aluOp     (aluOp),
    .pix_index (pix_index),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] reg_c;
    logic [7:0] sx;
    logic [6:0] sy;
    int         stop_at;   // plot index at which to stop, -1 for none
    int         stop_kind; // 1 abort, 2 reset
    bit         hold;      // keep go high during the draw
    int         exp_plots;
    bit         exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Region geometry straight from the region table.
  function automatic void dims(input logic [1:0] r, output int w, output int h);
    case (r)
      2'b00:   begin w = 160; h = 120; end
      2'b01:   begin w = 115; h = 70;  end
      default: begin w = 21;  h = 17;  end
    endcase
  endfunction

  task automatic run_draw(input logic [1:0] reg_c, input logic [7:0] sx, input logic [6:0] sy,
                          input int stop_at, input int stop_kind, input bit hold,
                          input int exp_plots, input bit exp_done);
    int w, h, fx, total, nplots;
    logic [7:0] esx;
    logic [6:0] esy;
    logic [63:0] act, exp;
    dims(reg_c, w, h);
    fx     = (reg_c == 2'b00) ? 1 : 0;
    esx    = (reg_c == 2'b00) ? 8'd0 : sx;
    esy    = (reg_c == 2'b00) ? 7'd0 : sy;
    total  = w * h;
    nplots = 0;
    region = reg_c; start_x_in = sx; start_y_in = sy; go = 1'b1;
    tick();
    if (!hold) go = 1'b0;
    for (int idx = 0; idx < total; idx++) begin
      act = 64'({plot, busy, done, err, Xpos, Ypos, startX, startY, aluOp, pix_index});
      exp = 64'({1'b1, 1'b1, 1'b0, 1'b0, 8'(fx + idx % w), 7'(idx / w), esx, esy, reg_c, 15'(idx)});
      check("plot_cycle", act, exp);
      if (plot) nplots++;
      if (idx == stop_at) begin
        if (stop_kind == 1) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          check("after_abort", 64'({plot, busy, done, Xpos, Ypos, pix_index}), 64'(0));
          check("abort_aluop", 64'(aluOp), 64'(reg_c));
          check("abort_plots", 64'(nplots), 64'(exp_plots));
          check("abort_done", 64'(exp_done), 64'(0));
        end else begin
          resetn = 1'b0;
          #1;
          check("async_reset", 64'({plot, busy, done, err, Xpos, Ypos, startX, startY, aluOp, pix_index}), 64'(0));
          tick();
          resetn = 1'b1;
          tick();
          check("post_reset", 64'({busy, plot, done, Xpos, Ypos, aluOp, pix_index}), 64'(0));
          check("reset_plots", 64'(nplots), 64'(exp_plots));
        end
        return;
      end
      tick();
    end
    check("done_pulse", 64'({plot, busy, done}), 64'({1'b0, 1'b1, exp_done}));
    tick();
    check("after_done", 64'({plot, busy, done, Xpos, Ypos, pix_index}), 64'(0));
    check("plot_count", 64'(nplots), 64'(exp_plots));
  endtask

  initial begin
    int gap, w, h, stop_at, kind, ep;
    logic [1:0] r;
    logic [7:0] sx;
    logic [6:0] sy;

    vecs[0] = '{2'b10, 8'd100, 7'd40, -1,  0, 1'b0, 357,   1'b1};
    vecs[1] = '{2'b00, 8'd50,  7'd50, -1,  0, 1'b0, 19200, 1'b1};
    vecs[2] = '{2'b01, 8'd20,  7'd10, -1,  0, 1'b1, 8050,  1'b1};
    vecs[3] = '{2'b01, 8'd20,  7'd10, -1,  0, 1'b0, 8050,  1'b1};
    vecs[4] = '{2'b01, 8'd30,  7'd20, 499, 1, 1'b0, 500,   1'b0};
    vecs[5] = '{2'b10, 8'd0,   7'd0,  356, 1, 1'b0, 357,   1'b0};
    vecs[6] = '{2'b10, 8'd5,   7'd5,  -1,  0, 1'b0, 357,   1'b1};

    resetn = 1'b0; go = 1'b0; region = 2'b00; start_x_in = '0; start_y_in = '0; abort = 1'b0;
    #1;
    check("reset_state", 64'({plot, busy, done, err, Xpos, Ypos, startX, startY, aluOp, pix_index}), 64'(0));
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check("idle_after_reset", 64'({plot, busy, done, err, aluOp}), 64'(0));

    foreach (vecs[i])
      run_draw(vecs[i].reg_c, vecs[i].sx, vecs[i].sy, vecs[i].stop_at, vecs[i].stop_kind,
               vecs[i].hold, vecs[i].exp_plots, vecs[i].exp_done);

    // Illegal region: err pulse only, latched ALU setup untouched.
    go = 1'b1; region = 2'b11; start_x_in = 8'd77; start_y_in = 7'd33;
    tick();
    go = 1'b0;
    check("err_pulse", 64'({err, busy, plot, done}), 64'(4'b1000));
    check("err_hold", 64'({aluOp, startX, startY}), 64'({2'b10, 8'd5, 7'd5}));
    tick();
    check("err_clear", 64'({err, busy, plot}), 64'(0));

    // Abort while idle has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", 64'({busy, plot, done, err, aluOp}), 64'({4'b0000, 2'b10}));

    // Reset in the middle of an answer draw.
    run_draw(2'b10, 8'd60, 7'd30, 100, 2, 1'b0, 101, 1'b0);

    // Randomized draws with idle gaps and occasional aborts.
    for (int k = 0; k < 8; k++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      r = 2'($urandom_range(1, 2));
      dims(r, w, h);
      sx = 8'($urandom_range(0, 160 - w));
      sy = 7'($urandom_range(0, 120 - h));
      if (r == 2'b01) begin
        stop_at = $urandom_range(0, 999);
        kind = 1;
      end else if ($urandom_range(0, 2) == 0) begin
        stop_at = $urandom_range(0, w * h - 1);
        kind = 1;
      end else begin
        stop_at = -1;
        kind = 0;
      end
      ep = (stop_at >= 0) ? stop_at + 1 : w * h;
      run_draw(r, sx, sy, stop_at, kind, 1'b0, ep, (stop_at < 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
